// File: rtl/tivi_pkg.sv
// tivi_pkg: shared VRAM geometry defaults and the arbiter slot-owner encoding.
package tivi_pkg;

    localparam int VRAM_AW_DEF = 14;
    localparam int VRAM_DW_DEF = 8;

    typedef enum logic [1:0] {IDLE, VID_RD, CPU_WR, CPU_RD} slot_e;

endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter: one-access-per-clock VRAM arbiter between display fetch, CPU write buffer and CPU read latch.
// Define VRAM_ARB_WRITE_BYPASS_EN to forward writes hitting the latched address straight into vdata_in.
module vram_arbiter
    import tivi_pkg::*;
#(
    parameter int VRAM_AW = VRAM_AW_DEF,
    parameter int VRAM_DW = VRAM_DW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic [VRAM_DW-1:0] cpu_wdata,
    input  logic               cpu_wren,
    output logic [VRAM_DW-1:0] vdata_in,
    output logic               vdata_valid,
    input  logic               vid_req,
    input  logic [VRAM_AW-1:0] vid_addr,
    output logic               vid_ack,
    output logic [VRAM_DW-1:0] vid_data,
    output logic               vid_data_valid,
    output logic [VRAM_AW-1:0] ram_addr,
    output logic [VRAM_DW-1:0] ram_wdata,
    output logic               ram_we,
    input  logic [VRAM_DW-1:0] ram_rdata
);

    slot_e               slot, prev_slot_q;
    logic                wb_full_q, rd_pend_q, vid_pend_q, lat_valid_q, lat_valid_d;
    logic [VRAM_AW-1:0]  wb_addr_q, rd_addr_q, lat_addr_q, lat_addr_d;
    logic [VRAM_DW-1:0]  wb_data_q, vdata_q, vdata_d;
    logic                stale, need_rd, wr_hit, cap_ok;

    assign stale   = !(lat_valid_q && cpu_addr == lat_addr_q);
    // A read already in flight for the current pointer will land next cycle; no duplicate fetch.
    assign need_rd = stale && !(rd_pend_q && rd_addr_q == cpu_addr);

    assign slot = reset                               ? IDLE
                : (vid_req && prev_slot_q != VID_RD)  ? VID_RD
                : wb_full_q                           ? CPU_WR
                : need_rd                             ? CPU_RD
                : vid_req                             ? VID_RD
                :                                       IDLE;

    assign ram_we    = slot == CPU_WR;
    assign vid_ack   = slot == VID_RD;
    assign ram_addr  = slot == VID_RD ? vid_addr
                     : slot == CPU_WR ? wb_addr_q
                     : slot == CPU_RD ? cpu_addr
                     :                  '0;
    assign ram_wdata = ram_we ? wb_data_q : '0;

    assign vid_data_valid = vid_pend_q && !reset;
    assign vid_data       = vid_data_valid ? ram_rdata : '0;
    assign vdata_in       = vdata_q;
    assign vdata_valid    = !reset && !stale;

    // A write landing on the address being captured this cycle must still win over the old read data.
    assign lat_addr_d = rd_pend_q ? rd_addr_q : lat_addr_q;
    assign wr_hit     = ram_we && wb_addr_q == lat_addr_d;
    assign cap_ok     = rd_pend_q ? cpu_addr == rd_addr_q : lat_valid_q;
`ifdef VRAM_ARB_WRITE_BYPASS_EN
    assign lat_valid_d = cap_ok;
    assign vdata_d     = wr_hit ? wb_data_q : rd_pend_q ? ram_rdata : vdata_q;
`else
    assign lat_valid_d = cap_ok && !wr_hit;
    assign vdata_d     = rd_pend_q ? ram_rdata : vdata_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_slot_q <= IDLE;
            wb_full_q   <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            vid_pend_q  <= 1'b0;
            lat_valid_q <= 1'b0;
            lat_addr_q  <= '0;
            vdata_q     <= '0;
        end else begin
            prev_slot_q <= slot;
            wb_full_q   <= cpu_wren || (wb_full_q && slot != CPU_WR);
            if (cpu_wren) begin
                wb_addr_q <= cpu_addr;
                wb_data_q <= cpu_wdata;
            end
            rd_pend_q   <= slot == CPU_RD;
            rd_addr_q   <= cpu_addr;
            vid_pend_q  <= slot == VID_RD;
            lat_valid_q <= lat_valid_d;
            lat_addr_q  <= lat_addr_d;
            vdata_q     <= vdata_d;
        end
    end

endmodule
